// File: rtl/i2c_bus_filter.sv
// I2C line conditioner: synchronises and deglitches raw SCL/SDA, then derives edge pulses,
// START/STOP detection and bus-busy status. Define I2C_FILTER_TIMEOUT_EN for the SCL stuck-low timeout.
module i2c_bus_filter #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic bus_timeout
);

    localparam int WARM_CYCLES = SYNC_STAGES + FILTER_LEN;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);
    localparam logic [3:0]        CNT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [WARM_W-1:0] WARM_END = WARM_W'(WARM_CYCLES);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("i2c_bus_filter: SYNC_STAGES must be 2..4");
        end
        if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
            $error("i2c_bus_filter: FILTER_LEN must be 1..15");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("i2c_bus_filter: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic [3:0]             scl_cnt_q, scl_cnt_d;
    logic [3:0]             sda_cnt_q, sda_cnt_d;
    logic                   scl_filt_q, scl_filt_d;
    logic                   sda_filt_q, sda_filt_d;
    logic [WARM_W-1:0]      warm_q, warm_d;
    logic                   armed_q, armed_d;
    logic                   scl_rise_q, scl_rise_d;
    logic                   scl_fall_q, scl_fall_d;
    logic                   start_q, start_d;
    logic                   stop_q, stop_d;
    logic                   busy_q, busy_d;
    logic                   timeout_d;
    logic                   scl_sync, sda_sync;

    assign scl_sync = scl_sync_q[SYNC_STAGES-1];
    assign sda_sync = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};

        // A new level is accepted only after FILTER_LEN consecutive disagreeing samples.
        scl_filt_d = scl_filt_q;
        scl_cnt_d  = '0;
        if (scl_sync != scl_filt_q) begin
            if (scl_cnt_q == CNT_LAST) begin
                scl_filt_d = scl_sync;
            end else begin
                scl_cnt_d = scl_cnt_q + 4'd1;
            end
        end

        sda_filt_d = sda_filt_q;
        sda_cnt_d  = '0;
        if (sda_sync != sda_filt_q) begin
            if (sda_cnt_q == CNT_LAST) begin
                sda_filt_d = sda_sync;
            end else begin
                sda_cnt_d = sda_cnt_q + 4'd1;
            end
        end

        // Arming waits until the pipeline has flushed its reset values and the bus is idle.
        warm_d  = (warm_q == WARM_END) ? warm_q : warm_q + WARM_W'(1);
        armed_d = armed_q | ((warm_q == WARM_END) & scl_filt_q & sda_filt_q);

        scl_rise_d = armed_q & ~scl_filt_q & scl_filt_d;
        scl_fall_d = armed_q & scl_filt_q & ~scl_filt_d;
        start_d    = armed_q & scl_filt_q & scl_filt_d & sda_filt_q & ~sda_filt_d;
        stop_d     = armed_q & scl_filt_q & scl_filt_d & ~sda_filt_q & sda_filt_d;

        busy_d = busy_q;
        if (start_d) begin
            busy_d = 1'b1;
        end
        if (stop_d || timeout_d) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            warm_q     <= '0;
            armed_q    <= 1'b0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
            warm_q     <= warm_d;
            armed_q    <= armed_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

`ifdef I2C_FILTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_END  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q;

    // Counts the clks SCL is held low during a transfer; saturates until SCL is released.
    always_comb begin
        to_cnt_d  = '0;
        timeout_d = 1'b0;
        if (scl_filt_d) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_END) begin
            to_cnt_d = to_cnt_q;
        end else if (busy_q) begin
            to_cnt_d  = to_cnt_q + TO_W'(1);
            timeout_d = (to_cnt_q == TO_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus_timeout = timeout_q;
`else
    assign timeout_d   = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    assign scl_o     = scl_filt_q;
    assign sda_o     = sda_filt_q;
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign bus_busy  = busy_q;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Bench for i2c_bus_filter: directed line patterns checked every cycle against a
// sample-history model of the bus, plus hand-computed latency and pulse-count checks.
module tb_i2c_bus_filter;

    localparam int SYNC = 2;
    localparam int FLEN = 4;
    localparam int TMO  = 1000;
    localparam int LAT  = SYNC + FLEN;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;
    logic scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout;

    int vectors     = 0;
    int miscompares = 0;

    i2c_bus_filter #(
        .SYNC_STAGES(SYNC),
        .FILTER_LEN(FLEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scl_in(scl_in),
        .sda_in(sda_in),
        .scl_o(scl_o),
        .sda_o(sda_o),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start_det(start_det),
        .stop_det(stop_det),
        .bus_busy(bus_busy),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: raw samples kept newest-first; a line's filtered level flips once the
    // FLEN samples that have cleared the synchroniser all disagree with it.
    logic hist_scl [LAT];
    logic hist_sda [LAT];
    logic m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_tmo, m_armed;
    logic p_scl, p_sda, p_busy, p_armed, flip_scl, flip_sda;
    int   m_edges, m_lowrun;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                hist_scl[i] = 1'b1;
                hist_sda[i] = 1'b1;
            end
            m_scl = 1'b1;  m_sda = 1'b1;
            m_rise = 1'b0; m_fall = 1'b0; m_start = 1'b0; m_stop = 1'b0;
            m_busy = 1'b0; m_tmo = 1'b0;  m_armed = 1'b0;
            m_edges = 0;   m_lowrun = 0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                hist_scl[i] = hist_scl[i-1];
                hist_sda[i] = hist_sda[i-1];
            end
            hist_scl[0] = scl_in;
            hist_sda[0] = sda_in;
            p_scl = m_scl; p_sda = m_sda; p_busy = m_busy; p_armed = m_armed;

            flip_scl = 1'b1;
            flip_sda = 1'b1;
            for (int i = SYNC; i < LAT; i++) begin
                if (hist_scl[i] == p_scl) flip_scl = 1'b0;
                if (hist_sda[i] == p_sda) flip_sda = 1'b0;
            end
            if (flip_scl) m_scl = ~p_scl;
            if (flip_sda) m_sda = ~p_sda;

`ifdef I2C_FILTER_TIMEOUT_EN
            if (!m_scl && p_busy) m_lowrun++;
            else m_lowrun = 0;
            m_tmo = (m_lowrun == TMO);
`else
            m_tmo = 1'b0;
`endif
            m_rise  = p_armed && !p_scl && m_scl;
            m_fall  = p_armed && p_scl && !m_scl;
            m_start = p_armed && p_scl && m_scl && p_sda && !m_sda;
            m_stop  = p_armed && p_scl && m_scl && !p_sda && m_sda;
            if (m_start) m_busy = 1'b1;
            if (m_stop || m_tmo) m_busy = 1'b0;

            m_edges++;
            if (m_edges > LAT && p_scl && p_sda) m_armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("scl_o", scl_o, m_scl);
        check("sda_o", sda_o, m_sda);
        check("scl_rise", scl_rise, m_rise);
        check("scl_fall", scl_fall, m_fall);
        check("start_det", start_det, m_start);
        check("stop_det", stop_det, m_stop);
        check("bus_busy", bus_busy, m_busy);
        check("bus_timeout", bus_timeout, m_tmo);
    end

    int c_rise, c_fall, c_start, c_stop, c_tmo;
    int lat_scl, lat_sda, lat_rise, lat_fall, lat_start, lat_stop, lat_tmo;

    task automatic drive(input logic s, input logic d);
        @(posedge clk);
        #3;
        scl_in = s;
        sda_in = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    // Index k = number of clock edges since the last drive() was sampled.
    task automatic observe(input int n);
        logic s0, d0;
        s0 = scl_o;
        d0 = sda_o;
        c_rise = 0; c_fall = 0; c_start = 0; c_stop = 0; c_tmo = 0;
        lat_scl = -1; lat_sda = -1; lat_rise = -1; lat_fall = -1;
        lat_start = -1; lat_stop = -1; lat_tmo = -1;
        @(negedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (scl_o != s0 && lat_scl < 0) lat_scl = k;
            if (sda_o != d0 && lat_sda < 0) lat_sda = k;
            if (scl_rise)  begin c_rise++;  if (lat_rise < 0)  lat_rise = k;  end
            if (scl_fall)  begin c_fall++;  if (lat_fall < 0)  lat_fall = k;  end
            if (start_det) begin c_start++; if (lat_start < 0) lat_start = k; end
            if (stop_det)  begin c_stop++;  if (lat_stop < 0)  lat_stop = k;  end
            if (bus_timeout) begin c_tmo++; if (lat_tmo < 0)   lat_tmo = k;   end
        end
    endtask

    initial begin
        idle(3);
        @(negedge clk);
        check("rst_scl_o", scl_o, 1);
        check("rst_sda_o", sda_o, 1);
        check("rst_busy", bus_busy, 0);
        check("rst_start", start_det, 0);
        @(posedge clk); #3;
        reset = 1'b0;
        idle(20);

        // 3-clk glitch is rejected
        drive(0, 1); idle(2); drive(1, 1);
        observe(12);
        check("glitch_scl_change", lat_scl, -1);
        check("glitch_fall_cnt", c_fall, 0);

        // 4-clk pulse is just long enough to pass
        drive(0, 1); idle(3); drive(1, 1);
        observe(14);
        check("pulse4_fall_k", lat_fall, 2);
        check("pulse4_rise_k", lat_rise, LAT);
        idle(4);

        // START then STOP with SCL high
        drive(1, 0);
        observe(12);
        check("start_sda_lat", lat_sda, LAT);
        check("start_k", lat_start, LAT);
        check("start_cnt", c_start, 1);
        check("start_busy", bus_busy, 1);
        drive(1, 1);
        observe(12);
        check("stop_k", lat_stop, LAT);
        check("stop_cnt", c_stop, 1);
        check("stop_busy", bus_busy, 0);
        idle(6);

        // transfer with a repeated START
        drive(1, 0); idle(9);
        drive(0, 0); idle(9);
        drive(0, 1); idle(9);
        drive(1, 1); idle(9);
        drive(0, 1); idle(9);
        drive(0, 0); idle(9);
        drive(1, 0); idle(9);
        drive(0, 0); idle(9);
        drive(0, 1); idle(9);
        drive(1, 1); idle(9);
        drive(1, 0);
        observe(12);
        check("rstart_cnt", c_start, 1);
        check("rstart_busy", bus_busy, 1);
        drive(0, 0); idle(9);
        drive(1, 0); idle(9);
        drive(1, 1);
        observe(12);
        check("rstop_cnt", c_stop, 1);
        check("rstop_busy", bus_busy, 0);
        idle(6);

        // simultaneous SCL/SDA change is not a START/STOP
        drive(0, 0);
        observe(12);
        check("same_fall_cnt", c_fall, 1);
        check("same_start_cnt", c_start, 0);
        check("same_sda_lat", lat_sda, LAT);
        drive(1, 1);
        observe(12);
        check("same_rise_cnt", c_rise, 1);
        check("same_stop_cnt", c_stop, 0);
        idle(6);

        // SCL stuck low inside a transfer
        drive(1, 0); idle(12);
        check("tmo_pre_busy", bus_busy, 1);
        drive(0, 0);
        observe(1100);
`ifdef I2C_FILTER_TIMEOUT_EN
        check("tmo_cnt", c_tmo, 1);
        check("tmo_k", lat_tmo, LAT + TMO - 1);
        check("tmo_busy", bus_busy, 0);
`else
        check("tmo_cnt", c_tmo, 0);
        check("tmo_k", lat_tmo, -1);
        check("tmo_busy", bus_busy, 1);
`endif
        drive(1, 0); idle(12);
        drive(1, 1); idle(12);
        check("tmo_end_busy", bus_busy, 0);

        // reset in the middle of a transfer
        drive(1, 0); idle(12);
        check("mid_busy", bus_busy, 1);
        @(posedge clk); #3;
        reset = 1'b1;
        idle(2);
        @(negedge clk);
        check("mid_rst_scl_o", scl_o, 1);
        check("mid_rst_sda_o", sda_o, 1);
        check("mid_rst_busy", bus_busy, 0);
        @(posedge clk); #3;
        reset = 1'b0;
        observe(30);
        check("post_rst_start", c_start, 0);
        check("post_rst_stop", c_stop, 0);
        check("post_rst_busy", bus_busy, 0);
        drive(1, 1); idle(15);
        check("post_idle_busy", bus_busy, 0);
        drive(1, 0);
        observe(12);
        check("post_start_cnt", c_start, 1);
        check("post_start_busy", bus_busy, 1);
        drive(1, 1); idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
